// File: rtl/nonce_sched.sv
// nonce_sched: walks one work unit's nonce range through the blake2b core.
// It issues one nonce per hash and samples the compare result when the
// core reports completion. Each winning nonce is held for the host until
// it is consumed. A per-hash watchdog ends the work unit if the core
// stalls.
// All outputs come straight from flops. Their next values are decoded from
// the next state, so they line up with the state register cycle for cycle.

module nonce_sched #(
   parameter int unsigned       NONCE_W = 64,
   parameter int unsigned       TMO_W   = 16,
   parameter logic [TMO_W-1:0]  TMO_MAX = 16'hFFFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               work_valid,
   output logic               work_ready,
   input  logic [NONCE_W-1:0] nonce_lo,
   input  logic [NONCE_W-1:0] nonce_hi,
   input  logic               abort,
   output logic               core_start,
   output logic [NONCE_W-1:0] core_nonce,
   input  logic               core_done,
   input  logic               found,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [NONCE_W-1:0] res_nonce,
   output logic               busy,
   output logic               exhausted,
   output logic               timeout
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   // A core_done seen while the watchdog holds this value is still
   // accepted. Without core_done, the hash times out at the end of that
   // cycle. This gives the core TMO_MAX cycles after its start pulse.
   localparam logic [TMO_W-1:0]   WD_LAST  = TMO_MAX - {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0]   WD_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0]   WD_ZERO  = {TMO_W{1'b0}};
   localparam logic [NONCE_W-1:0] N_ONE    = {{(NONCE_W-1){1'b0}}, 1'b1};
   localparam logic [NONCE_W-1:0] N_ZERO   = {NONCE_W{1'b0}};

   state_t               state_q, state_d;
   logic [NONCE_W-1:0]   cur_q, cur_d;
   logic [NONCE_W-1:0]   hi_q, hi_d;
   logic [TMO_W-1:0]     wd_q, wd_d;

   logic                 work_ready_q, work_ready_d;
   logic                 busy_q, busy_d;
   logic                 core_start_q, core_start_d;
   logic [NONCE_W-1:0]   core_nonce_q, core_nonce_d;
   logic                 res_valid_q, res_valid_d;
   logic [NONCE_W-1:0]   res_nonce_q, res_nonce_d;
   logic                 exhausted_q, exhausted_d;
   logic                 timeout_q, timeout_d;

   logic                 last_s;
   logic                 work_hs_s;
   logic                 res_hs_s;

   assign last_s    = (cur_q == hi_q);
   assign work_hs_s = work_valid && work_ready_q;
   assign res_hs_s  = res_valid_q && res_ready;

   // Next-state, range walker, watchdog and sticky status logic.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      hi_d        = hi_q;
      wd_d        = wd_q;
      res_valid_d = res_valid_q;
      res_nonce_d = res_nonce_q;
      exhausted_d = exhausted_q;
      timeout_d   = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (work_hs_s) begin
               // A reversed range collapses to the single nonce nonce_lo.
               if (nonce_lo > nonce_hi) begin
                  hi_d = nonce_lo;
               end else begin
                  hi_d = nonce_hi;
               end
               cur_d       = nonce_lo;
               exhausted_d = 1'b0;
               timeout_d   = 1'b0;
               state_d     = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ISSUE: begin
            if (abort) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               wd_d    = WD_ZERO;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (abort) begin
               // abort overrides a simultaneous completion
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else if (core_done) begin
               if (found) begin
                  res_nonce_d = cur_q;
                  res_valid_d = 1'b1;
                  state_d     = ST_REPORT;
               end else if (last_s) begin
                  exhausted_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  cur_d   = cur_q + N_ONE;
                  state_d = ST_ISSUE;
               end
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               wd_d = wd_q + WD_ONE;
            end
         end

         ST_REPORT: begin
            if (abort) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else if (res_hs_s) begin
               res_valid_d = 1'b0;
               if (last_s) begin
                  exhausted_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  // cur only advances below hi, so an all-ones hi never wraps
                  cur_d   = cur_q + N_ONE;
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = ST_REPORT;
            end
         end

         default: begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the output flops track the state flop.
   always_comb begin
      work_ready_d = 1'b0;
      busy_d       = 1'b0;
      core_start_d = 1'b0;
      core_nonce_d = core_nonce_q;
      if (state_d == ST_IDLE) begin
         work_ready_d = 1'b1;
         busy_d       = 1'b0;
      end else begin
         work_ready_d = 1'b0;
         busy_d       = 1'b1;
      end
      if (state_d == ST_ISSUE) begin
         core_start_d = 1'b1;
         core_nonce_d = cur_d;
      end else begin
         core_start_d = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Range walker and watchdog registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_q <= N_ZERO;
         hi_q  <= N_ZERO;
         wd_q  <= WD_ZERO;
      end else begin
         cur_q <= cur_d;
         hi_q  <= hi_d;
         wd_q  <= wd_d;
      end
   end

   // Registered host- and core-facing outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         work_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         core_start_q <= 1'b0;
         core_nonce_q <= N_ZERO;
         res_valid_q  <= 1'b0;
         res_nonce_q  <= N_ZERO;
         exhausted_q  <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         work_ready_q <= work_ready_d;
         busy_q       <= busy_d;
         core_start_q <= core_start_d;
         core_nonce_q <= core_nonce_d;
         res_valid_q  <= res_valid_d;
         res_nonce_q  <= res_nonce_d;
         exhausted_q  <= exhausted_d;
         timeout_q    <= timeout_d;
      end
   end

   assign work_ready = work_ready_q;
   assign busy       = busy_q;
   assign core_start = core_start_q;
   assign core_nonce = core_nonce_q;
   assign res_valid  = res_valid_q;
   assign res_nonce  = res_nonce_q;
   assign exhausted  = exhausted_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_nonce_sched.sv
// Testbench for nonce_sched. The bench plays both the host and the blake2b
// core. The expected nonce order, result reports and end-of-unit status
// are derived from the range rules. The bench drives and samples on the
// falling clock edge.

module tb_nonce_sched;

   localparam int unsigned      NW  = 64;
   localparam int unsigned      TW  = 16;
   localparam logic [TW-1:0]    TMO = 16'd40;

   logic          clk;
   logic          rst;
   logic          work_valid;
   logic          work_ready;
   logic [NW-1:0] nonce_lo;
   logic [NW-1:0] nonce_hi;
   logic          abort;
   logic          core_start;
   logic [NW-1:0] core_nonce;
   logic          core_done;
   logic          found;
   logic          res_valid;
   logic          res_ready;
   logic [NW-1:0] res_nonce;
   logic          busy;
   logic          exhausted;
   logic          timeout;

   int checks = 0;
   int errors = 0;

   nonce_sched #(.NONCE_W(NW), .TMO_W(TW), .TMO_MAX(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .work_valid (work_valid),
      .work_ready (work_ready),
      .nonce_lo   (nonce_lo),
      .nonce_hi   (nonce_hi),
      .abort      (abort),
      .core_start (core_start),
      .core_nonce (core_nonce),
      .core_done  (core_done),
      .found      (found),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_nonce  (res_nonce),
      .busy       (busy),
      .exhausted  (exhausted),
      .timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string pre);
      chk({pre, "_work_ready"}, work_ready, 1'b1);
      chk({pre, "_core_start"}, core_start, 1'b0);
      chk({pre, "_core_nonce"}, core_nonce, 64'd0);
      chk({pre, "_res_valid"},  res_valid,  1'b0);
      chk({pre, "_res_nonce"},  res_nonce,  64'd0);
      chk({pre, "_busy"},       busy,       1'b0);
      chk({pre, "_exhausted"},  exhausted,  1'b0);
      chk({pre, "_timeout"},    timeout,    1'b0);
   endtask

   // Runs one complete work unit. The core answers each hash after a random
   // (or fixed) delay. A hash hits when it is the forced winner, or else
   // with probability hit_pct percent.
   task automatic run_unit(input logic [63:0] lo, input logic [63:0] hi,
                           input int hit_pct, input logic hit_en,
                           input logic [63:0] hit_nonce, input int delay_fix);
      logic [63:0] n_exp;
      logic [63:0] exp_nonce;
      int          d;
      int          h;
      logic        f;
      @(negedge clk);
      chk("idle_ready", work_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      work_valid = 1'b1;
      nonce_lo   = lo;
      nonce_hi   = hi;
      n_exp      = (lo > hi) ? 64'd1 : (hi - lo + 64'd1);
      @(negedge clk);
      work_valid = 1'b0;
      nonce_lo   = {$urandom, $urandom};
      nonce_hi   = {$urandom, $urandom};
      chk("clr_exhausted", exhausted, 1'b0);
      chk("clr_timeout", timeout, 1'b0);
      for (longint unsigned i = 0; i < n_exp; i++) begin
         exp_nonce = lo + i;
         chk("start_pulse", core_start, 1'b1);
         chk("start_nonce", core_nonce, exp_nonce);
         d = (delay_fix > 0) ? delay_fix : int'($urandom_range(5, 1));
         f = (hit_en && (exp_nonce == hit_nonce)) || (int'($urandom_range(99, 0)) < hit_pct);
         for (int k = 0; k < d; k++) begin
            found = 1'($urandom);
            @(negedge clk);
            chk("wait_start_low", core_start, 1'b0);
            chk("wait_nonce_hold", core_nonce, exp_nonce);
            chk("wait_busy", busy, 1'b1);
         end
         core_done = 1'b1;
         found     = f;
         @(negedge clk);
         core_done = 1'b0;
         found     = 1'b0;
         if (f) begin
            h = (hit_en && (exp_nonce == hit_nonce)) ? 10 : int'($urandom_range(3, 0));
            chk("res_valid", res_valid, 1'b1);
            chk("res_nonce", res_nonce, exp_nonce);
            chk("res_no_start", core_start, 1'b0);
            for (int k = 0; k < h; k++) begin
               @(negedge clk);
               chk("hold_res_valid", res_valid, 1'b1);
               chk("hold_res_nonce", res_nonce, exp_nonce);
               chk("hold_no_start", core_start, 1'b0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk("res_consumed", res_valid, 1'b0);
         end
         if (i == n_exp - 64'd1) begin
            chk("end_exhausted", exhausted, 1'b1);
            chk("end_busy", busy, 1'b0);
            chk("end_work_ready", work_ready, 1'b1);
            chk("end_no_start", core_start, 1'b0);
            chk("end_timeout", timeout, 1'b0);
         end
      end
   endtask

   initial begin
      logic [63:0] rlo;
      rst        = 1'b0;
      work_valid = 1'b0;
      nonce_lo   = 64'd0;
      nonce_hi   = 64'd0;
      abort      = 1'b0;
      core_done  = 1'b0;
      found      = 1'b0;
      res_ready  = 1'b0;

      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b1;

      // short range, never found
      run_unit(64'h10, 64'h13, 0, 1'b0, 64'd0, 0);

      // long range with one winner held for 10 cycles
      run_unit(64'h100, 64'h1FF, 0, 1'b1, 64'h105, 0);

      // all-ones single nonce must not wrap to zero
      run_unit(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 64'd0, 0);
      chk("allones_nonce_nonzero", (core_nonce == 64'd0), 1'b0);

      // reversed range hashes only nonce_lo
      run_unit(64'h50, 64'h40, 50, 1'b0, 64'd0, 0);

      // near the top of the nonce space with random hits
      run_unit(64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 50, 1'b0, 64'd0, 0);

      // core answers on the last allowed cycle
      run_unit(64'h5, 64'h5, 0, 1'b0, 64'd0, int'(TMO));

      // random ranges and hit pattern
      for (int u = 0; u < 6; u++) begin
         rlo = {$urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF;
         run_unit(rlo, rlo + 64'($urandom_range(6, 0)), 30, 1'b0, 64'd0, 0);
      end

      // watchdog: core never answers
      @(negedge clk);
      work_valid = 1'b1;
      nonce_lo   = 64'h77;
      nonce_hi   = 64'h80;
      @(negedge clk);
      work_valid = 1'b0;
      chk("tmo_start", core_start, 1'b1);
      for (int k = 1; k <= int'(TMO); k++) begin
         @(negedge clk);
         chk("tmo_not_yet", timeout, 1'b0);
         chk("tmo_busy", busy, 1'b1);
      end
      @(negedge clk);
      chk("tmo_set", timeout, 1'b1);
      chk("tmo_idle", busy, 1'b0);
      chk("tmo_ready", work_ready, 1'b1);
      chk("tmo_no_exh", exhausted, 1'b0);
      // late completion in IDLE is ignored
      core_done = 1'b1;
      found     = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      found     = 1'b0;
      chk("late_done_res", res_valid, 1'b0);
      chk("late_done_busy", busy, 1'b0);
      chk("tmo_sticky", timeout, 1'b1);

      // abort together with a winning completion
      @(negedge clk);
      work_valid = 1'b1;
      nonce_lo   = 64'h20;
      nonce_hi   = 64'h30;
      @(negedge clk);
      work_valid = 1'b0;
      chk("abort_start", core_start, 1'b1);
      @(negedge clk);
      core_done = 1'b1;
      found     = 1'b1;
      abort     = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      found     = 1'b0;
      abort     = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_res_valid", res_valid, 1'b0);
      chk("abort_exhausted", exhausted, 1'b0);
      chk("abort_timeout", timeout, 1'b0);
      chk("abort_ready", work_ready, 1'b1);
      chk("abort_no_start", core_start, 1'b0);

      // abort while a result waits for the host
      @(negedge clk);
      work_valid = 1'b1;
      nonce_lo   = 64'h40;
      nonce_hi   = 64'h41;
      @(negedge clk);
      work_valid = 1'b0;
      @(negedge clk);
      core_done = 1'b1;
      found     = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      found     = 1'b0;
      chk("rep_res_valid", res_valid, 1'b1);
      chk("rep_res_nonce", res_nonce, 64'h40);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("rep_abort_res_valid", res_valid, 1'b0);
      chk("rep_abort_busy", busy, 1'b0);
      chk("rep_abort_exhausted", exhausted, 1'b0);

      // asynchronous reset in the middle of a hash
      @(negedge clk);
      work_valid = 1'b1;
      nonce_lo   = 64'h90;
      nonce_hi   = 64'h99;
      @(negedge clk);
      work_valid = 1'b0;
      chk("rst_pre_start", core_start, 1'b1);
      @(negedge clk);
      chk("rst_pre_busy", busy, 1'b1);
      #1 rst = 1'b0;
      #1 chk_reset("async_rst");
      @(negedge clk);
      rst = 1'b1;
      chk_reset("rst_release");

      // normal operation resumes after reset
      run_unit(64'hA0, 64'hA3, 40, 1'b0, 64'd0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
